// File: rtl/led_matrix_bcm_scheduler_if.sv
// Control/status bundle between the frame-buffer side and the BCM line scheduler.
interface led_matrix_bcm_scheduler_if #(
  parameter int unsigned SCAN_ROWS   = 16,
  parameter int unsigned COLOR_DEPTH = 8
);
  localparam int unsigned ROW_W   = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
  localparam int unsigned PLANE_W = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;

  logic               run;
  logic [7:0]         prescale_div;
  logic               swap_req;
  logic               line_sync;
  logic               prescaler_enable;
  logic               prescaler_bypass;
  logic [ROW_W-1:0]   row_addr;
  logic [PLANE_W-1:0] bitplane;
  logic               buffer_sel;
  logic               swap_ack;
  logic               frame_start;
  logic               busy;

  modport master (
    output run, prescale_div, swap_req, line_sync,
    input  prescaler_enable, prescaler_bypass, row_addr, bitplane,
           buffer_sel, swap_ack, frame_start, busy
  );

  modport slave (
    input  run, prescale_div, swap_req, line_sync,
    output prescaler_enable, prescaler_bypass, row_addr, bitplane,
           buffer_sel, swap_ack, frame_start, busy
  );
endinterface

// File: rtl/led_matrix_bcm_scheduler.sv
// Row/bitplane sequencer for binary-coded-modulation LED matrix scanning,
// with driver step prescaler and frame-aligned double-buffer select.
module led_matrix_bcm_scheduler #(
  parameter int unsigned SCAN_ROWS   = 16,
  parameter int unsigned COLOR_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  led_matrix_bcm_scheduler_if.slave bus
);
  localparam int unsigned ROW_W   = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
  localparam int unsigned PLANE_W = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam int unsigned DIV_W   = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [COLOR_DEPTH-1:0] rep_q, rep_d, rep_lim;
  logic [DIV_W-1:0]   div_q, div_d, pcnt_q, pcnt_d;
  logic               buf_q, buf_d;
  logic               ack_q, ack_d;
  logic               fs_q, fs_d;
  logic               hold_q, hold_d;

  logic active, divided, pcnt_wrap, line_adv;
  logic last_rep, last_plane, last_row, frame_end;

  // Plane b is held for 2^b lines: repeat limit is b ones in the low bits.
  always_comb begin
    rep_lim = '0;
    for (int i = 0; i < int'(COLOR_DEPTH); i++) begin
      rep_lim[i] = (PLANE_W'(i) < plane_q);
    end
  end

  assign active     = (state_q != IDLE);
  assign divided    = (div_q >= DIV_W'(2));
  assign pcnt_wrap  = (pcnt_q == div_q - DIV_W'(1));
  assign line_adv   = active & bus.line_sync;
  assign last_rep   = (rep_q == rep_lim);
  assign last_plane = (plane_q == PLANE_W'(COLOR_DEPTH - 1));
  assign last_row   = (row_q == ROW_W'(SCAN_ROWS - 1));
  assign frame_end  = line_adv & last_rep & last_plane & last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      rep_q   <= '0;
      div_q   <= '0;
      pcnt_q  <= '0;
      buf_q   <= 1'b0;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      rep_q   <= rep_d;
      div_q   <= div_d;
      pcnt_q  <= pcnt_d;
      buf_q   <= buf_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    rep_d   = rep_q;
    div_d   = div_q;
    buf_d   = buf_q;
    ack_d   = 1'b0;
    fs_d    = 1'b0;
    // An acked request must be released before another idle swap is taken.
    hold_d  = hold_q & bus.swap_req;
    pcnt_d  = '0;

    if (active && divided) begin
      pcnt_d = pcnt_wrap ? '0 : pcnt_q + DIV_W'(1);
    end

    if (line_adv) begin
      if (!last_rep) begin
        rep_d = rep_q + COLOR_DEPTH'(1);
      end else begin
        rep_d = '0;
        if (!last_plane) begin
          plane_d = plane_q + PLANE_W'(1);
        end else begin
          plane_d = '0;
          row_d   = last_row ? '0 : row_q + ROW_W'(1);
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.swap_req && !hold_q) begin
          buf_d  = ~buf_q;
          ack_d  = 1'b1;
          hold_d = 1'b1;
        end
        if (bus.run) begin
          state_d = RUN;
          div_d   = bus.prescale_div;
          row_d   = '0;
          plane_d = '0;
          rep_d   = '0;
          pcnt_d  = '0;
          fs_d    = 1'b1;
        end
      end
      RUN: begin
        if (!bus.run) state_d = frame_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (bus.run)        state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Frame boundary: restart pulse and the only point a running swap may land.
    if (frame_end) begin
      if (state_d != IDLE) fs_d = 1'b1;
      if (bus.swap_req) begin
        buf_d  = ~buf_q;
        ack_d  = 1'b1;
        hold_d = 1'b1;
      end
    end
  end

  assign bus.row_addr         = row_q;
  assign bus.bitplane         = plane_q;
  assign bus.buffer_sel       = buf_q;
  assign bus.swap_ack         = ack_q;
  assign bus.frame_start      = fs_q;
  assign bus.busy             = active;
  assign bus.prescaler_bypass = active & ~divided;
  assign bus.prescaler_enable = active & divided & pcnt_wrap;
endmodule

// File: tb/tb_led_matrix_bcm_scheduler.sv
// Directed self-checking bench for led_matrix_bcm_scheduler (2 rows, 3-bit colour).
module tb_led_matrix_bcm_scheduler;
  localparam int unsigned SR = 2;
  localparam int unsigned CD = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_matrix_bcm_scheduler_if #(.SCAN_ROWS(SR), .COLOR_DEPTH(CD)) bus ();
  led_matrix_bcm_scheduler #(.SCAN_ROWS(SR), .COLOR_DEPTH(CD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    bit sync;
    int row;
    int plane;
    int fs;
  } vec_t;

  vec_t tbl[14];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_pulse();
    bus.line_sync = 1'b1;
    tick();
    bus.line_sync = 1'b0;
  endtask

  // Pulse one line and compare position against table entry k.
  task automatic line_chk(input string tag, input int k);
    sync_pulse();
    chk($sformatf("%s row line%0d", tag, k + 1), int'(bus.row_addr), tbl[k].row);
    chk($sformatf("%s plane line%0d", tag, k + 1), int'(bus.bitplane), tbl[k].plane);
  endtask

  initial begin
    int er[14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    int ep[14] = '{1, 1, 2, 2, 2, 2, 0, 1, 1, 2, 2, 2, 2, 0};
    for (int i = 0; i < 14; i++) begin
      tbl[i].sync  = 1'b1;
      tbl[i].row   = er[i];
      tbl[i].plane = ep[i];
      tbl[i].fs    = (i == 13) ? 1 : 0;
    end

    rst_n            = 1'b0;
    bus.run          = 1'b0;
    bus.prescale_div = 8'd0;
    bus.swap_req     = 1'b0;
    bus.line_sync    = 1'b0;

    // Reset state
    #12;
    chk("rst busy", int'(bus.busy), 0);
    chk("rst row", int'(bus.row_addr), 0);
    chk("rst plane", int'(bus.bitplane), 0);
    chk("rst buf", int'(bus.buffer_sel), 0);
    chk("rst bypass", int'(bus.prescaler_bypass), 0);
    chk("rst enable", int'(bus.prescaler_enable), 0);
    chk("rst fs", int'(bus.frame_start), 0);
    chk("rst ack", int'(bus.swap_ack), 0);
    rst_n = 1'b1;
    tick();
    chk("idle busy", int'(bus.busy), 0);

    // Bypass run, one full frame from the vector table
    bus.run = 1'b1;
    tick();
    chk("start fs", int'(bus.frame_start), 1);
    chk("start busy", int'(bus.busy), 1);
    chk("start bypass", int'(bus.prescaler_bypass), 1);
    tick();
    chk("start fs drop", int'(bus.frame_start), 0);
    for (int i = 0; i < 14; i++) begin
      bus.line_sync = tbl[i].sync;
      tick();
      bus.line_sync = 1'b0;
      chk($sformatf("tbl row %0d", i), int'(bus.row_addr), tbl[i].row);
      chk($sformatf("tbl plane %0d", i), int'(bus.bitplane), tbl[i].plane);
      chk($sformatf("tbl fs %0d", i), int'(bus.frame_start), tbl[i].fs);
      chk($sformatf("tbl bypass %0d", i), int'(bus.prescaler_bypass), 1);
      chk($sformatf("tbl enable %0d", i), int'(bus.prescaler_enable), 0);
    end

    // Drain: run drops at line 5, re-raised at line 9, dropped again to stop
    for (int i = 0; i < 4; i++) line_chk("drn", i);
    bus.run = 1'b0;
    tick();
    chk("drain busy", int'(bus.busy), 1);
    for (int i = 4; i < 8; i++) line_chk("drn", i);
    chk("drain busy2", int'(bus.busy), 1);
    bus.run = 1'b1;
    tick();
    chk("rerun row", int'(bus.row_addr), 1);
    chk("rerun plane", int'(bus.bitplane), 1);
    chk("rerun fs", int'(bus.frame_start), 0);
    bus.run = 1'b0;
    tick();
    for (int i = 8; i < 13; i++) line_chk("drn", i);
    chk("drain busy3", int'(bus.busy), 1);
    sync_pulse();
    chk("stop busy", int'(bus.busy), 0);
    chk("stop bypass", int'(bus.prescaler_bypass), 0);
    chk("stop fs", int'(bus.frame_start), 0);
    chk("stop row", int'(bus.row_addr), 0);
    chk("stop plane", int'(bus.bitplane), 0);

    // Idle: line_sync ignored, swaps immediate with release required
    for (int i = 0; i < 3; i++) sync_pulse();
    chk("idle sync row", int'(bus.row_addr), 0);
    chk("idle sync plane", int'(bus.bitplane), 0);
    chk("idle sync busy", int'(bus.busy), 0);
    bus.swap_req = 1'b1;
    tick();
    chk("idle swap buf", int'(bus.buffer_sel), 1);
    chk("idle swap ack", int'(bus.swap_ack), 1);
    tick();
    chk("idle held ack", int'(bus.swap_ack), 0);
    chk("idle held buf", int'(bus.buffer_sel), 1);
    bus.swap_req = 1'b0;
    tick();
    bus.swap_req = 1'b1;
    tick();
    chk("idle swap2 buf", int'(bus.buffer_sel), 0);
    chk("idle swap2 ack", int'(bus.swap_ack), 1);
    bus.swap_req = 1'b0;
    tick();
    chk("idle swap2 ack drop", int'(bus.swap_ack), 0);

    // Divided prescaler: period 4 fixed at entry, continuous through DRAIN
    bus.prescale_div = 8'd4;
    bus.run = 1'b1;
    tick();
    bus.prescale_div = 8'd2;
    chk("div fs", int'(bus.frame_start), 1);
    chk("div bypass", int'(bus.prescaler_bypass), 0);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      chk($sformatf("div enable c%0d", c), int'(bus.prescaler_enable), (c % 4 == 0) ? 1 : 0);
      if (c == 6) bus.run = 1'b0;
      if (c == 8) chk("div drain busy", int'(bus.busy), 1);
      if (c == 10) bus.run = 1'b1;
    end

    // Swap requested mid-frame lands only at frame ends
    for (int i = 0; i < 3; i++) line_chk("swp", i);
    bus.swap_req = 1'b1;
    for (int i = 3; i < 13; i++) begin
      line_chk("swp", i);
      chk($sformatf("swp hold buf line%0d", i + 1), int'(bus.buffer_sel), 0);
      chk($sformatf("swp hold ack line%0d", i + 1), int'(bus.swap_ack), 0);
    end
    sync_pulse();
    chk("swp fe buf", int'(bus.buffer_sel), 1);
    chk("swp fe ack", int'(bus.swap_ack), 1);
    chk("swp fe fs", int'(bus.frame_start), 1);
    tick();
    chk("swp ack single", int'(bus.swap_ack), 0);
    for (int i = 0; i < 13; i++) sync_pulse();
    chk("swp2 mid buf", int'(bus.buffer_sel), 1);
    sync_pulse();
    chk("swp2 fe buf", int'(bus.buffer_sel), 0);
    chk("swp2 fe ack", int'(bus.swap_ack), 1);
    bus.swap_req = 1'b0;

    // Async reset mid-frame with buffer_sel=1
    bus.swap_req = 1'b1;
    for (int i = 0; i < 14; i++) sync_pulse();
    bus.swap_req = 1'b0;
    chk("pre-rst buf", int'(bus.buffer_sel), 1);
    for (int i = 0; i < 10; i++) sync_pulse();
    chk("pre-rst row", int'(bus.row_addr), 1);
    chk("pre-rst plane", int'(bus.bitplane), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst row", int'(bus.row_addr), 0);
    chk("arst plane", int'(bus.bitplane), 0);
    chk("arst buf", int'(bus.buffer_sel), 0);
    chk("arst busy", int'(bus.busy), 0);
    chk("arst enable", int'(bus.prescaler_enable), 0);
    chk("arst bypass", int'(bus.prescaler_bypass), 0);
    bus.prescale_div = 8'd0;
    #1 rst_n = 1'b1;
    tick();
    chk("post-rst busy", int'(bus.busy), 1);
    chk("post-rst fs", int'(bus.frame_start), 1);
    chk("post-rst bypass", int'(bus.prescaler_bypass), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
